fifo_sync_cfg: RTL and testbench
================================

Name: fifo_sync_cfg

Overview:
- Single-clock synchronous FIFO; parametrised successor to the team's fifo_if-attached FIFO.
- Generalised in DATA_WIDTH, DEPTH and programmable almost-full/almost-empty thresholds.
- Adds a selectable read mode (registered or first-word-fall-through), a live fill count and sticky overflow/underflow error flags.
- Sits between a producer and consumer in the datapath. Its signal set matches the slave side of fifo_if, plus the extra status ports.

Parameters:
- DATA_WIDTH, 32, data word width in bits.
- DEPTH, 16, number of entries; power of two, >= 4.
- AFULL_THRESH, 14, almost_full asserts when count >= AFULL_THRESH; range 1..DEPTH.
- AEMPTY_THRESH, 2, almost_empty asserts when count <= AEMPTY_THRESH; range 0..DEPTH-1.
- FWFT, 0, read mode. 0 = registered read (data one cycle after ren). 1 = first-word-fall-through.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  reset.
- wdata  in  DATA_WIDTH  write data.
- wen  in  1  write request.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AFULL_THRESH.
- rdata  out  DATA_WIDTH  read data.
- rvalid  out  1  rdata valid qualifier.
- ren  in  1  read request.
- empty  out  1  count == 0.
- almost_empty  out  1  count <= AEMPTY_THRESH.
- count  out  $clog2(DEPTH)+1  current number of stored entries.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.
- clr_err  in  1  clears overflow/underflow.

Behaviour:
- Interface (decided): one clock, clk; reset rstn is synchronous and active-low.
- Reset values (rstn low at a clk edge):
  - wr_ptr = rd_ptr = 0, count = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - rvalid = 0, rdata = 0, overflow = 0, underflow = 0.
  - Storage array is not cleared; its contents are discarded.
- Reset asserted mid-operation: any pending rvalid is dropped the same edge.
- Write accept: wen && !full.
  - wdata is stored at wr_ptr; wr_ptr = (wr_ptr+1) mod DEPTH.
- Read accept: ren && !empty; rd_ptr = (rd_ptr+1) mod DEPTH.
- Flag decode: full/empty/almost flags are evaluated against the registered count of the current cycle.
- Full with wen and ren in the same cycle: the read is accepted, the write is rejected, overflow is set.
- Empty with wen and ren in the same cycle: the write is accepted, the read is rejected, underflow is set.
- Count update (next edge):
  - +1 on write-only.
  - -1 on read-only.
  - Unchanged when both are accepted, or when neither is accepted.
- All status flags are registered and derived from the next count, so they change on the same edge as count.
- FWFT=0 mode:
  - Read accepted at edge N: rdata = mem[rd_ptr] and rvalid = 1 after edge N (one-cycle latency).
  - rvalid is a 1-cycle pulse per accepted read.
  - rdata holds its last value when no read occurs.
- FWFT=1 mode:
  - rdata continuously presents the head entry; rvalid = !empty.
  - ren acts as a pop/acknowledge, and the next entry appears the cycle after the pop.
  - Write into an empty FIFO at edge N: rvalid = 1 and rdata = that word after edge N.
  - rdata is don't-care while rvalid = 0.
- Error flags:
  - overflow is set on wen && full; underflow is set on ren && empty.
  - Both stay set until clr_err is sampled high.
  - If a set condition and clr_err occur in the same cycle, set wins.
- Pointer wrap: pointers wrap with no gap; a full FIFO holds exactly DEPTH words, with no reserved slot.
- Data ordering: strict first-in, first-out; no word is duplicated or lost on any accepted transfer.

Test Plan:
- Reset then fill, FWFT=0, DEPTH=16: write 0x00..0x0F. count reaches 16, full=1; almost_full=1 from count 14; empty=0 after the first write.
- Drain, FWFT=0: ren for 16 cycles. rvalid pulses each following cycle with rdata 0x00..0x0F in order. Then empty=1, almost_empty=1 at count<=2, count=0.
- Boundary collisions:
  - When full: wen+ren together. One word is read, the write is dropped, count=15, overflow=1.
  - When empty: wen+ren together. count=1, underflow=1.
  - Then pulse clr_err: both flags return to 0.
- FWFT=1 streaming: write 0xA5 into empty. Next cycle rvalid=1, rdata=0xA5. Then continuous wen+ren for 100 cycles: count stays constant, wrap-around passes and data stays in order.
- Reset mid-stream: with count=9 and a read in flight, drive rstn=0 for one edge. Next cycle count=0, empty=1, rvalid=0, overflow/underflow=0.

Source files
------------

// File: rtl/fifo_sync_cfg.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// selectable registered or first-word-fall-through read, fill count and sticky error flags.
module fifo_sync_cfg #(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = 14,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic                       wen,
  output logic                       full,
  output logic                       almost_full,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic                       rvalid,
  input  logic                       ren,
  output logic                       empty,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [AW-1:0]         rd_ptr_next_s;
  logic [CW-1:0]         count_r;
  logic [CW-1:0]         count_next_s;
  logic                  wr_acc_s;
  logic                  rd_acc_s;
  logic [DATA_WIDTH-1:0] head_s;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic                  rvalid_r;
  logic                  full_r;
  logic                  almost_full_r;
  logic                  empty_r;
  logic                  almost_empty_r;
  logic                  overflow_r;
  logic                  underflow_r;

  // Accept decode, next count, and the word that will sit at the head after this edge
  always_comb begin
    wr_acc_s      = wen && !full_r;
    rd_acc_s      = ren && !empty_r;
    rd_ptr_next_s = rd_acc_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
    // The new word becomes the head when nothing else remains in front of it.
    if (wr_acc_s && (count_r == (rd_acc_s ? CW'(1) : CW'(0)))) begin
      head_s = wdata;
    end else begin
      head_s = mem[rd_ptr_next_s];
    end
  end

  // Storage array; never reset, contents discarded on reset via the pointers
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem[wr_ptr_r] <= wdata;
    end
  end

  // Pointers, count, status flags and read port
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_r       <= '0;
      rd_ptr_r       <= '0;
      count_r        <= '0;
      full_r         <= 1'b0;
      almost_full_r  <= 1'b0;
      empty_r        <= 1'b1;
      almost_empty_r <= 1'b1;
      overflow_r     <= 1'b0;
      underflow_r    <= 1'b0;
      rvalid_r       <= 1'b0;
      rdata_r        <= '0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      rd_ptr_r       <= rd_ptr_next_s;
      count_r        <= count_next_s;
      full_r         <= (count_next_s == CW'(DEPTH));
      almost_full_r  <= (count_next_s >= CW'(AFULL_THRESH));
      empty_r        <= (count_next_s == CW'(0));
      almost_empty_r <= (count_next_s <= CW'(AEMPTY_THRESH));
      overflow_r     <= (wen && full_r) || (overflow_r && !clr_err);
      underflow_r    <= (ren && empty_r) || (underflow_r && !clr_err);
      if (FWFT != 0) begin
        rvalid_r <= (count_next_s != CW'(0));
        rdata_r  <= head_s;
      end else begin
        rvalid_r <= rd_acc_s;
        if (rd_acc_s) begin
          rdata_r <= mem[rd_ptr_r];
        end
      end
    end
  end

  assign full         = full_r;
  assign almost_full  = almost_full_r;
  assign empty        = empty_r;
  assign almost_empty = almost_empty_r;
  assign count        = count_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;
  assign rvalid       = rvalid_r;
  assign rdata        = rdata_r;

endmodule

// File: tb/tb_fifo_sync_cfg.sv
// Bench driving a registered-read and an FWFT instance with identical stimulus,
// checked against a queue-based model of the FIFO rules.
module tb_fifo_sync_cfg;

  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          wen;
  logic          ren;
  logic          clr_err;
  logic [DW-1:0] wdata;

  logic [DW-1:0] rdata0, rdata1;
  logic [4:0]    count0, count1;
  logic          full0, full1, af0, af1, empty0, empty1, ae0, ae1;
  logic          rv0, rv1, ov0, ov1, un0, un1;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q[$];
  bit            m_ov, m_un, m_rv0;
  logic [DW-1:0] m_rd0;

  always #5 clk = ~clk;

  fifo_sync_cfg #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(14), .AEMPTY_THRESH(2), .FWFT(0)) dut0 (
    .clk(clk), .rstn(rstn), .wdata(wdata), .wen(wen), .full(full0), .almost_full(af0),
    .rdata(rdata0), .rvalid(rv0), .ren(ren), .empty(empty0), .almost_empty(ae0),
    .count(count0), .overflow(ov0), .underflow(un0), .clr_err(clr_err));

  fifo_sync_cfg #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(14), .AEMPTY_THRESH(2), .FWFT(1)) dut1 (
    .clk(clk), .rstn(rstn), .wdata(wdata), .wen(wen), .full(full1), .almost_full(af1),
    .rdata(rdata1), .rvalid(rv1), .ren(ren), .empty(empty1), .almost_empty(ae1),
    .count(count1), .overflow(ov1), .underflow(un1), .clr_err(clr_err));

  wire [23:0] dut_stat = {count0, empty0, full0, af0, ae0, ov0, un0, rv0,
                          count1, empty1, full1, af1, ae1, ov1, un1, rv1};

  // Expected status of both instances from the model's occupancy and error state.
  function automatic logic [23:0] exp_stat();
    int n;
    logic [11:0] base0, base1;
    n = q.size();
    base0 = {5'(n), (n == 0), (n == DEPTH), (n >= 14), (n <= 2), m_ov, m_un, m_rv0};
    base1 = {5'(n), (n == 0), (n == DEPTH), (n >= 14), (n <= 2), m_ov, m_un, (n != 0)};
    return {base0, base1};
  endfunction

  // One clock of stimulus; the model applies the FIFO rules to its pre-edge state.
  task automatic drive(input bit rst, input bit w, input bit r, input bit c, input logic [DW-1:0] d);
    bit full_m, empty_m;
    rstn = !rst; wen = w; ren = r; clr_err = c; wdata = d;
    full_m  = (q.size() == DEPTH);
    empty_m = (q.size() == 0);
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete(); m_ov = 1'b0; m_un = 1'b0; m_rv0 = 1'b0; m_rd0 = '0;
    end else begin
      m_ov  = (w && full_m) || (m_ov && !c);
      m_un  = (r && empty_m) || (m_un && !c);
      m_rv0 = r && !empty_m;
      if (r && !empty_m) m_rd0 = q.pop_front();
      if (w && !full_m) q.push_back(d);
    end
    rstn = 1'b1; wen = 1'b0; ren = 1'b0; clr_err = 1'b0;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h1234);
    checks++;
    if (dut_stat !== exp_stat()) begin
      errors++; $display("FAIL reset_status got %h exp %h", dut_stat, exp_stat());
    end
    checks++;
    if (rdata0 !== 32'h0) begin
      errors++; $display("FAIL reset_rdata got %h exp %h", rdata0, 32'h0);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, DW'(i));
      checks++;
      if (dut_stat !== exp_stat()) begin
        errors++; $display("FAIL fill_status[%0d] got %h exp %h", i, dut_stat, exp_stat());
      end
    end
    checks++;
    if ({count0, full0, af0, empty0} !== {5'd16, 1'b1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL fill_full got %h exp %h", {count0, full0, af0, empty0}, {5'd16, 3'b110});
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
      checks++;
      if (dut_stat !== exp_stat()) begin
        errors++; $display("FAIL drain_status[%0d] got %h exp %h", i, dut_stat, exp_stat());
      end
      checks++;
      if (rv0 !== 1'b1 || rdata0 !== DW'(i)) begin
        errors++; $display("FAIL drain_data[%0d] got %0b/%h exp 1/%h", i, rv0, rdata0, DW'(i));
      end
    end
    checks++;
    if ({count0, empty0, ae0} !== {5'd0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL drain_empty got %h exp %h", {count0, empty0, ae0}, {5'd0, 2'b11});
    end
  endtask

  task automatic test_collisions();
    for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h100 + DW'(i));
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'hDEAD);
    checks++;
    if ({count0, ov0, rv0, rdata0} !== {5'd15, 1'b1, 1'b1, 32'h100}) begin
      errors++; $display("FAIL full_collision got %0d/%b/%b/%h exp 15/1/1/100", count0, ov0, rv0, rdata0);
    end
    checks++;
    if (dut_stat !== exp_stat()) begin
      errors++; $display("FAIL full_collision_status got %h exp %h", dut_stat, exp_stat());
    end
    for (int i = 0; i < DEPTH - 1; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'hBEEF);
    checks++;
    if ({count0, un0, ov0, rv1, rdata1} !== {5'd1, 1'b1, 1'b1, 1'b1, 32'hBEEF}) begin
      errors++; $display("FAIL empty_collision got %0d/%b/%b/%b/%h exp 1/1/1/1/beef", count0, un0, ov0, rv1, rdata1);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
    checks++;
    if ({ov0, un0, ov1, un1} !== 4'b0000) begin
      errors++; $display("FAIL clr_err got %b exp 0000", {ov0, un0, ov1, un1});
    end
    checks++;
    if (dut_stat !== exp_stat()) begin
      errors++; $display("FAIL clr_err_status got %h exp %h", dut_stat, exp_stat());
    end
  endtask

  task automatic test_fwft_stream();
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'hA5);
    checks++;
    if (rv1 !== 1'b1 || rdata1 !== 32'hA5) begin
      errors++; $display("FAIL fwft_first got %b/%h exp 1/a5", rv1, rdata1);
    end
    for (int i = 0; i < 100; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h1000 + DW'(i));
      checks++;
      if (dut_stat !== exp_stat() || count1 !== 5'd1) begin
        errors++; $display("FAIL stream_status[%0d] got %h exp %h", i, dut_stat, exp_stat());
      end
      checks++;
      if (rdata1 !== q[0] || rdata0 !== m_rd0) begin
        errors++; $display("FAIL stream_data[%0d] got %h/%h exp %h/%h", i, rdata1, rdata0, q[0], m_rd0);
      end
    end
  endtask

  task automatic test_random();
    bit w, r, c;
    for (int i = 0; i < 800; i++) begin
      // Alternate fill-biased and drain-biased phases to sweep the whole occupancy range.
      if (((i / 100) % 2) == 0) begin
        w = ($urandom_range(0, 9) < 7); r = ($urandom_range(0, 9) < 3);
      end else begin
        w = ($urandom_range(0, 9) < 3); r = ($urandom_range(0, 9) < 7);
      end
      c = ($urandom_range(0, 15) == 0);
      drive(1'b0, w, r, c, $urandom());
      checks++;
      if (dut_stat !== exp_stat()) begin
        errors++; $display("FAIL rand_status[%0d] got %h exp %h", i, dut_stat, exp_stat());
      end
      checks++;
      if (rdata0 !== m_rd0 || (q.size() != 0 && rdata1 !== q[0])) begin
        errors++; $display("FAIL rand_data[%0d] got %h/%h exp %h/%h", i, rdata0, rdata1, m_rd0,
                           (q.size() != 0) ? q[0] : 32'h0);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h200 + DW'(i));
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h300);
    drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
    checks++;
    if ({count0, rv0, un0} !== {5'd9, 1'b1, 1'b1}) begin
      errors++; $display("FAIL pre_reset got %0d/%b/%b exp 9/1/1", count0, rv0, un0);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h400);
    checks++;
    if ({count0, empty0, rv0, rv1, ov0, un0} !== {5'd0, 1'b1, 4'b0000}) begin
      errors++; $display("FAIL reset_mid got %h exp %h", {count0, empty0, rv0, rv1, ov0, un0}, {5'd0, 5'b10000});
    end
    checks++;
    if (dut_stat !== exp_stat()) begin
      errors++; $display("FAIL reset_mid_status got %h exp %h", dut_stat, exp_stat());
    end
  endtask

  initial begin
    rstn = 1'b0; wen = 1'b0; ren = 1'b0; clr_err = 1'b0; wdata = '0;
    m_ov = 1'b0; m_un = 1'b0; m_rv0 = 1'b0; m_rd0 = '0;
    test_reset();
    test_fill();
    test_drain();
    test_collisions();
    test_fwft_stream();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
